// File: rtl/dram_arbiter.sv
// Shares one external DRAM port between NUM_REQ engines and tracks outstanding reads per tenure.
// Build option: define ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module dram_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned NUM_REQ    = 3,
  parameter int unsigned MAX_OUTST  = 8
) (
  input  logic                           clk,
  input  logic                           srstn,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ-1:0]             rd_en_req,
  input  logic [NUM_REQ-1:0]             wr_en_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_in_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  addr_out_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  data_out_req,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             valid_req,
  output logic                           stall,
  output logic                           err,
  input  logic                           dram_valid,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic [ADDR_WIDTH-1:0]          addr_in,
  output logic [ADDR_WIDTH-1:0]          addr_out,
  output logic                           dram_en_wr,
  output logic                           dram_en_rd
);

  localparam int unsigned OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_DRAIN} state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [OWN_W-1:0]     owner_q, owner_d;
  logic [OWN_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]     outst_q, outst_d;
  logic                 err_q, err_d;

  logic [OWN_W-1:0]     arb_start;
  logic [OWN_W-1:0]     win_idx;
  logic                 win_found;
  logic                 outst_full;
  logic                 valid_ok;

  logic [ADDR_WIDTH-1:0] rd_addr_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0] wr_addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_data_arr [NUM_REQ];

  // Unpack per-requester address/data buses
  always_comb begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      rd_addr_arr[i] = addr_in_req[i*ADDR_WIDTH +: ADDR_WIDTH];
      wr_addr_arr[i] = addr_out_req[i*ADDR_WIDTH +: ADDR_WIDTH];
      wr_data_arr[i] = data_out_req[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Winner search: first set req bit at or after arb_start, wrapping
  always_comb begin
    int unsigned idx;
`ifdef ARB_FIXED_PRIO_EN
    arb_start = '0;
`else
    arb_start = rr_ptr_q;
`endif
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(arb_start) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = OWN_W'(idx);
      end
    end
  end

  // Next-state, DRAM forwarding and outstanding-read bookkeeping
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    outst_d    = outst_q;
    err_d      = err_q;
    data_out   = '0;
    addr_in    = '0;
    addr_out   = '0;
    dram_en_wr = 1'b0;
    dram_en_rd = 1'b0;
    stall      = 1'b0;
    valid_req  = '0;
    outst_full = (outst_q == CNT_W'(MAX_OUTST));
    valid_ok   = dram_valid && (outst_q != '0);

    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          gnt_d   = NUM_REQ'(1) << win_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        data_out = wr_data_arr[owner_q];
        addr_in  = rd_addr_arr[owner_q];
        addr_out = wr_addr_arr[owner_q];
        if (req[owner_q]) begin
          dram_en_wr = wr_en_req[owner_q];
          dram_en_rd = rd_en_req[owner_q] && !outst_full;
          stall      = rd_en_req[owner_q] && outst_full;
        end else begin
          gnt_d   = '0;
          state_d = ST_DRAIN;
`ifndef ARB_FIXED_PRIO_EN
          if (owner_q == OWN_W'(NUM_REQ - 1)) rr_ptr_d = '0;
          else                                rr_ptr_d = owner_q + OWN_W'(1);
`endif
        end
      end
      ST_DRAIN: begin
        if (outst_q == '0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (valid_ok) valid_req[owner_q] = 1'b1;
    if (dram_valid && (outst_q == '0)) err_d = 1'b1;

    case ({dram_en_rd, valid_ok})
      2'b10:   outst_d = outst_q + CNT_W'(1);
      2'b01:   outst_d = outst_q - CNT_W'(1);
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!srstn) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      outst_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      outst_q  <= outst_d;
      err_q    <= err_d;
    end
  end

  assign gnt = gnt_q;
  assign err = err_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Scoreboard bench for dram_arbiter: read addresses and routed valids are queued at issue and checked on output.
module tb_dram_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 18;
  localparam int unsigned NR = 3;
  localparam int unsigned MO = 4;
  localparam int unsigned LAT = 3;

  logic            clk = 1'b0;
  logic            srstn;
  logic [NR-1:0]   req, rd_en_req, wr_en_req;
  logic [NR*AW-1:0] addr_in_req, addr_out_req;
  logic [NR*DW-1:0] data_out_req;
  logic [NR-1:0]   gnt, valid_req;
  logic            stall, err, dram_valid;
  logic [DW-1:0]   data_out;
  logic [AW-1:0]   addr_in, addr_out;
  logic            dram_en_wr, dram_en_rd;

  logic            model_en, model_valid, man_valid;
  int              cyc, n_tests, n_fail, vr_seen;
  int              tb_owner;
  logic [AW-1:0]   exp_addr_q [$];
  logic [NR-1:0]   exp_vr_q [$];
  int              due_q [$];

  assign dram_valid = model_valid | man_valid;

  always #5 clk = ~clk;

  dram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REQ(NR), .MAX_OUTST(MO)) dut (
    .clk(clk), .srstn(srstn), .req(req), .rd_en_req(rd_en_req), .wr_en_req(wr_en_req),
    .addr_in_req(addr_in_req), .addr_out_req(addr_out_req), .data_out_req(data_out_req),
    .gnt(gnt), .valid_req(valid_req), .stall(stall), .err(err), .dram_valid(dram_valid),
    .data_out(data_out), .addr_in(addr_in), .addr_out(addr_out),
    .dram_en_wr(dram_en_wr), .dram_en_rd(dram_en_rd)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_rd(input int r, input logic [AW-1:0] a);
    addr_in_req[r*AW +: AW] = a;
  endtask

  task automatic set_wr(input int r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr_out_req[r*AW +: AW] = a;
    data_out_req[r*DW +: DW] = d;
  endtask

  task automatic do_reset();
    srstn = 1'b0;
    step();
    srstn = 1'b1;
  endtask

  // DRAM latency model: returns one dram_valid LAT cycles after each forwarded read
  initial begin
    cyc = 0;
    model_valid = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (model_en && due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        model_valid = 1'b1;
      end else begin
        model_valid = 1'b0;
      end
    end
  end

  // Scoreboard: forwarded read addresses
  always @(negedge clk) begin
    if (dram_en_rd) begin
      if (exp_addr_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
      else                        check("rd_addr", 32'(addr_in), 32'(exp_addr_q.pop_front()));
      if (model_en) begin
        due_q.push_back(cyc + LAT);
        exp_vr_q.push_back(NR'(1) << tb_owner);
      end
    end
  end

  // Scoreboard: valid routed to the read owner
  always @(negedge clk) begin
    if (model_valid) begin
      if (exp_vr_q.size() == 0) check("vr_unexpected", 32'd1, 32'd0);
      else                      check("valid_req", 32'(valid_req), 32'(exp_vr_q.pop_front()));
      vr_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         granted;
    int           ptr, own;
    logic [NR-1:0] exp_g;
    n_tests = 0; n_fail = 0; vr_seen = 0; tb_owner = 0;
    model_en = 1'b0; man_valid = 1'b0;
    addr_in_req = '0; addr_out_req = '0; data_out_req = '0;

    // Reset with every request asserted
    srstn = 1'b0; req = '1; rd_en_req = '1; wr_en_req = '1;
    repeat (2) step();
    sample();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_en_rd", 32'(dram_en_rd), 32'd0);
    check("rst_en_wr", 32'(dram_en_wr), 32'd0);
    check("rst_addr_in", 32'(addr_in), 32'd0);
    check("rst_addr_out", 32'(addr_out), 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_valid_req", 32'(valid_req), 32'd0);
    step();
    srstn = 1'b1; req = '0; rd_en_req = '0; wr_en_req = '0;
    step();

    // Three reads through requester 0, then drain before granting requester 1
    model_en = 1'b1; tb_owner = 0;
    req = 3'b001;
    step();
    sample();
    check("t2_gnt", 32'(gnt), 32'b001);
    for (int i = 0; i < 3; i++) begin
      step();
      rd_en_req = 3'b001;
      set_rd(0, AW'(5 + i));
      exp_addr_q.push_back(AW'(5 + i));
      wr_en_req = (i == 0) ? 3'b010 : (i == 2) ? 3'b001 : 3'b000;
      if (i == 2) set_wr(0, AW'(9), 32'hABCD_0123);
      set_wr(1, AW'(77), 32'h5555_AAAA);
      sample();
      if (i == 0) check("t2_no_leak_wr", 32'(dram_en_wr), 32'd0);
      if (i == 2) begin
        check("t2_rdwr_wr", 32'(dram_en_wr), 32'd1);
        check("t2_addr_out", 32'(addr_out), 32'd9);
        check("t2_data_out", data_out, 32'hABCD_0123);
      end
    end
    step();
    req = 3'b010; rd_en_req = 3'b001; wr_en_req = '0;
    sample();
    check("t2_drop_en_rd", 32'(dram_en_rd), 32'd0);
    check("t2_drop_gnt", 32'(gnt), 32'b001);
    step();
    rd_en_req = '0;
    granted = 1'b0;
    for (int i = 0; i < 30 && !granted; i++) begin
      sample();
      if (gnt != '0) granted = 1'b1;
      else step();
    end
    check("t2_next_gnt", 32'(gnt), 32'b010);
    check("t2_valids_before_regrant", 32'(vr_seen), 32'd3);
    step();
    req = '0;
    repeat (3) step();
    model_en = 1'b0;

    // Fairness with all requesters contending
    do_reset();
    req = 3'b111;
    ptr = 0;
    for (int g = 0; g < 4; g++) begin
`ifdef ARB_FIXED_PRIO_EN
      own = 0;
`else
      own = ptr;
`endif
      exp_g = NR'(1) << own;
      granted = 1'b0;
      for (int i = 0; i < 10 && !granted; i++) begin
        sample();
        if (gnt != '0) granted = 1'b1;
        else step();
      end
      check("t3_gnt_order", 32'(gnt), 32'(exp_g));
      ptr = (own + 1) % NR;
      repeat (4) step();
      req = 3'b111 & ~exp_g;
      step();
      req = 3'b111;
    end
    req = '0;
    repeat (3) step();

    // Outstanding limit: six back-to-back reads, no returns
    do_reset();
    req = 3'b001;
    step();
    sample();
    check("t4_gnt", 32'(gnt), 32'b001);
    for (int i = 0; i < 6; i++) begin
      step();
      rd_en_req = 3'b001;
      set_rd(0, AW'(100 + i));
      if (i < int'(MO)) exp_addr_q.push_back(AW'(100 + i));
      sample();
      check("t4_en_rd", 32'(dram_en_rd), (i < int'(MO)) ? 32'd1 : 32'd0);
      check("t4_stall", 32'(stall), (i < int'(MO)) ? 32'd0 : 32'd1);
    end
    step();
    req = '0; rd_en_req = '0;

    // Spurious dram_valid while idle
    do_reset();
    step();
    sample();
    check("t5_err_before", 32'(err), 32'd0);
    step();
    man_valid = 1'b1;
    sample();
    check("t5_valid_req", 32'(valid_req), 32'd0);
    step();
    man_valid = 1'b0;
    sample();
    check("t5_err_set", 32'(err), 32'd1);
    repeat (3) step();
    sample();
    check("t5_err_sticky", 32'(err), 32'd1);

    // Reset mid-tenure with three reads in flight
    step();
    do_reset();
    req = 3'b001;
    step();
    sample();
    check("t6_gnt", 32'(gnt), 32'b001);
    for (int i = 0; i < 3; i++) begin
      step();
      rd_en_req = 3'b001;
      set_rd(0, AW'(200 + i));
      exp_addr_q.push_back(AW'(200 + i));
    end
    step();
    srstn = 1'b0; rd_en_req = '0;
    step();
    sample();
    check("t6_rst_gnt", 32'(gnt), 32'd0);
    check("t6_rst_err", 32'(err), 32'd0);
    step();
    srstn = 1'b1; req = 3'b010;
    step();
    sample();
    check("t6_regrant", 32'(gnt), 32'b010);
    step();
    man_valid = 1'b1;
    sample();
    check("t6_valid_req_zero", 32'(valid_req), 32'd0);
    step();
    man_valid = 1'b0;
    sample();
    check("t6_outst_cleared", 32'(err), 32'd1);

    check("addr_queue_empty", 32'(exp_addr_q.size()), 32'd0);
    check("vr_queue_empty", 32'(exp_vr_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
